// File: rtl/prog_loader_pkg.sv
// Shared widths, command target codes and FSM state encodings for the program loader.
package prog_loader_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned ST_W   = 4;

   localparam logic [1:0] TGT_ACC = 2'b00;
   localparam logic [1:0] TGT_MEM = 2'b01;
   localparam logic [1:0] TGT_END = 2'b10;

   localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
   localparam logic [ST_W-1:0] ST_CMD    = 4'd1;
   localparam logic [ST_W-1:0] ST_ACCD   = 4'd2;
   localparam logic [ST_W-1:0] ST_STRB_A = 4'd3;
   localparam logic [ST_W-1:0] ST_ADDR   = 4'd4;
   localparam logic [ST_W-1:0] ST_MDAT   = 4'd5;
   localparam logic [ST_W-1:0] ST_STRB_M = 4'd6;
   localparam logic [ST_W-1:0] ST_DONE   = 4'd7;
   localparam logic [ST_W-1:0] ST_ERR    = 4'd8;

endpackage

// File: rtl/prog_loader_addr_ctr.sv
// Loadable wrapping up-counter holding the program RAM write address.
module prog_loader_addr_ctr
   import prog_loader_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ld_i,
   input  logic [ADDR_W-1:0] ld_val_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] cnt_o
);

   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // Load has priority; increment wraps naturally at the top of the address space.
   always_comb begin
      cnt_d = cnt_q;
      if (ld_i)
         cnt_d = ld_val_i;
      else if (inc_i)
         cnt_d = ADDR_W'(cnt_q + 1'b1);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream driven loader: writes the Accumulator and program RAM through one-cycle
// strobes, holding the CPU halted for the duration of a session.
module prog_loader
   import prog_loader_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] prog_data,
   output logic [ADDR_W-1:0] prog_addr,
   output logic              acc_load,
   output logic              mem_load,
   output logic              halt_cpu,
   output logic              busy,
   output logic              done,
   output logic              err
);

   logic [ST_W-1:0]   state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              addr_ld, addr_inc, xfer;
   logic              in_ready_q, in_ready_d;
   logic              acc_q, acc_d, mem_q, mem_d;
   logic              halt_q, halt_d, busy_q, busy_d;
   logic              done_q, done_d, err_q, err_d;

   prog_loader_addr_ctr u_addr_ctr (
      .CLK      (CLK),
      .RESET    (RESET),
      .ld_i     (addr_ld),
      .ld_val_i (in_data[ADDR_W-1:0]),
      .inc_i    (addr_inc),
      .cnt_o    (prog_addr)
   );

   assign xfer = in_valid & in_ready_q;

   // Next state plus datapath controls; every output flop is decoded from the next state.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      addr_ld  = 1'b0;
      addr_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CMD;
               err_d   = 1'b0;
            end
         end
         ST_CMD: begin
            if (xfer) begin
               case (in_data[DATA_W-1 -: 2])
                  TGT_ACC: state_d = ST_ACCD;
                  TGT_MEM: begin
                     state_d = ST_ADDR;
                     cnt_d   = in_data[CNT_W-1:0];
                  end
                  TGT_END: state_d = ST_DONE;
                  default: begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end
               endcase
            end
         end
         ST_ACCD: begin
            if (xfer) begin
               data_d  = in_data;
               state_d = ST_STRB_A;
            end
         end
         ST_STRB_A: state_d = ST_CMD;
         ST_ADDR: begin
            if (xfer) begin
               addr_ld = 1'b1;
               state_d = ST_MDAT;
            end
         end
         ST_MDAT: begin
            if (xfer) begin
               data_d  = in_data;
               state_d = ST_STRB_M;
            end
         end
         ST_STRB_M: begin
            addr_inc = 1'b1;
            if (cnt_q == '0) begin
               state_d = ST_CMD;
            end else begin
               cnt_d   = CNT_W'(cnt_q - 1'b1);
               state_d = ST_MDAT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_CMD) || (state_d == ST_ACCD) ||
                   (state_d == ST_ADDR) || (state_d == ST_MDAT);
      acc_d      = (state_d == ST_STRB_A);
      mem_d      = (state_d == ST_STRB_M);
      done_d     = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE);
      halt_d     = busy_d && (state_d != ST_DONE) && (state_d != ST_ERR);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         data_q     <= '0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         acc_q      <= 1'b0;
         mem_q      <= 1'b0;
         halt_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         acc_q      <= acc_d;
         mem_q      <= mem_d;
         halt_q     <= halt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign prog_data = data_q;
   assign acc_load  = acc_q;
   assign mem_load  = mem_q;
   assign halt_cpu  = halt_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: a command-level model predicts strobe/done/err events; a monitor checks them.
module tb_prog_loader;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       start = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, acc_load, mem_load, halt_cpu, busy, done, err;
   logic [7:0] prog_data, prog_addr;

   typedef struct { int kind; logic [7:0] addr; logic [7:0] data; } ev_t;
   typedef logic [7:0] bq_t[$];

   localparam int EV_ACC = 0, EV_MEM = 1, EV_DONE = 2, EV_ERR = 3;

   ev_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   prog_loader dut (
      .CLK(CLK), .RESET(RESET), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .prog_data(prog_data), .prog_addr(prog_addr),
      .acc_load(acc_load), .mem_load(mem_load), .halt_cpu(halt_cpu), .busy(busy),
      .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, got, want);
      end
   endtask

   function automatic void push_ev(input int k, input logic [7:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endfunction

   // Walk the command stream and list the events a correct loader must produce.
   function automatic void model_session(input bq_t b);
      int         i = 0;
      int         n;
      logic [7:0] c, a;
      a = 8'h00;
      while (i < b.size()) begin
         c = b[i];
         i++;
         case (c[7:6])
            2'b00: begin push_ev(EV_ACC, 8'h00, b[i]); i++; end
            2'b01: begin
               n = int'(c[5:0]);
               a = b[i];
               i++;
               for (int k = 0; k <= n; k++) begin
                  push_ev(EV_MEM, a, b[i]);
                  i++;
                  a = a + 8'd1;
               end
            end
            2'b10: begin push_ev(EV_DONE, 8'h00, 8'h00); return; end
            default: begin push_ev(EV_ERR, 8'h00, 8'h00); return; end
         endcase
      end
   endfunction

   function automatic bq_t gen_session();
      bq_t b;
      int  nc, n;
      nc = $urandom_range(0, 4);
      for (int j = 0; j < nc; j++) begin
         if ($urandom_range(0, 1) == 0) begin
            b.push_back({2'b00, 6'($urandom)});
            b.push_back(8'($urandom));
         end else begin
            n = $urandom_range(0, 5);
            b.push_back({2'b01, 6'(n)});
            b.push_back(8'($urandom));
            for (int k = 0; k <= n; k++) b.push_back(8'($urandom));
         end
      end
      if ($urandom_range(0, 4) == 0) b.push_back({2'b11, 6'($urandom)});
      else                           b.push_back({2'b10, 6'($urandom)});
      return b;
   endfunction

   task automatic pulse_start();
      @(posedge CLK); #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
   endtask

   // Offer one byte after a random stall; spurious start pulses while busy must be ignored.
   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1 in_valid = 1'b1;
      in_data = b;
      start = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("in_ready timeout", 0, 1);
      else begin @(posedge CLK); #1; end
      in_valid = 1'b0;
      start = 1'b0;
      in_data = 8'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
      if (exp_q.size() != 0) begin
         chk("events outstanding", exp_q.size(), 0);
         exp_q.delete();
      end
      @(posedge CLK); #1;
      chk("busy after end", int'(busy), 0);
      chk("halt after end", int'(halt_cpu), 0);
   endtask

   task automatic run_session(input bq_t b);
      model_session(b);
      pulse_start();
      foreach (b[i]) send_byte(b[i]);
      wait_idle();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " in_ready"}, int'(in_ready), 0);
      chk({tag, " prog_data"}, int'(prog_data), 0);
      chk({tag, " prog_addr"}, int'(prog_addr), 0);
      chk({tag, " acc_load"}, int'(acc_load), 0);
      chk({tag, " mem_load"}, int'(mem_load), 0);
      chk({tag, " halt_cpu"}, int'(halt_cpu), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " err"}, int'(err), 0);
   endtask

   // Monitor: every strobe, done pulse or err rise must match the head of the queue.
   initial begin : monitor
      logic err_prev;
      ev_t  e;
      int   k;
      err_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RESET) begin
            if (acc_load && mem_load) chk("strobe overlap", 1, 0);
            if (acc_load || mem_load || done || (err && !err_prev)) begin
               k = acc_load ? EV_ACC : mem_load ? EV_MEM : done ? EV_DONE : EV_ERR;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected event: got kind %0d, required none", k);
               end else begin
                  e = exp_q.pop_front();
                  chk("event kind", k, e.kind);
                  if (k == EV_MEM) begin
                     chk("mem addr", int'(prog_addr), int'(e.addr));
                     chk("mem data", int'(prog_data), int'(e.data));
                  end
                  if (k == EV_ACC) chk("acc data", int'(prog_data), int'(e.data));
                  if (k < EV_DONE) begin
                     chk("halt during strobe", int'(halt_cpu), 1);
                     chk("in_ready during strobe", int'(in_ready), 0);
                  end else begin
                     chk("halt at end", int'(halt_cpu), 0);
                  end
                  if (k == EV_DONE) chk("err at done", int'(err), 0);
               end
            end
         end
         err_prev = err;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bq_t b;
      repeat (3) @(posedge CLK);
      #1 chk_all_zero("reset");
      RESET = 1'b0;

      b = {8'h00, 8'h5A, 8'h80};
      run_session(b);
      chk("acc prog_data held", int'(prog_data), 'h5A);

      b = {8'h42, 8'h10, 8'h11, 8'h22, 8'h33, 8'h80};
      run_session(b);

      b = {8'h41, 8'hFF, 8'hAA, 8'hBB, 8'h80};
      run_session(b);
      chk("addr after wrap", int'(prog_addr), 'h01);
      chk("err after clean end", int'(err), 0);

      b = {8'hC0};
      run_session(b);
      repeat (3) @(posedge CLK);
      #1;
      chk("err sticky", int'(err), 1);
      chk("halt after err", int'(halt_cpu), 0);
      chk("busy after err", int'(busy), 0);
      pulse_start();
      chk("err cleared by start", int'(err), 0);
      chk("busy after start", int'(busy), 1);
      chk("halt after start", int'(halt_cpu), 1);
      b = {8'h80};
      model_session(b);
      send_byte(8'h80);
      wait_idle();

      for (int s = 0; s < 25; s++) begin
         b = gen_session();
         run_session(b);
      end

      // Reset after the second of four burst bytes has been strobed.
      push_ev(EV_MEM, 8'h20, 8'h01);
      push_ev(EV_MEM, 8'h21, 8'h02);
      pulse_start();
      send_byte(8'h43);
      send_byte(8'h20);
      send_byte(8'h01);
      send_byte(8'h02);
      @(negedge CLK);
      #1 RESET = 1'b1;
      #1 chk_all_zero("mid-burst reset");
      chk("events before reset", exp_q.size(), 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1 in_valid = 1'($urandom); in_data = 8'($urandom);
      end
      RESET = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1 in_valid = 1'($urandom); in_data = 8'($urandom);
      end
      in_valid = 1'b0;
      @(posedge CLK); #1;
      chk_all_zero("after reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
